stdp_synapse: RTL and testbench

//  Receiving end of the LIF spike interface: consumes pre- and post-synaptic spike pulses,

---
 rtl/stdp_pkg.sv | 18 +
 rtl/stdp_trace.sv | 41 ++++
 rtl/stdp_synapse.sv | 177 +++++++++++++++++
 tb/tb_stdp_synapse.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/stdp_pkg.sv
// Shared definitions for the STDP synapse: FSM state encodings,
// the trace width helper and the default trace reload value.
package stdp_pkg;

    // Default eligibility trace reload value (power of two)
    localparam int TRACE_MAX_DEFAULT = 16;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LTP  = 2'd1;
    localparam logic [1:0] ST_LTD  = 2'd2;

    // Width of a trace register able to hold trace_max itself
    function automatic int trace_w(input int trace_max);
        return $clog2(trace_max) + 1;
    endfunction

endpackage

// File: rtl/stdp_trace.sv
// Eligibility trace counter: reloads to TRACE_MAX on a spike and
// halves on every edge without one (16-8-4-2-1-0).
module stdp_trace
    import stdp_pkg::*;
#(
    parameter int TRACE_MAX = TRACE_MAX_DEFAULT,
    parameter int TW        = trace_w(TRACE_MAX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spike_i,
    output logic [TW-1:0] trace_o
);

    localparam logic [TW-1:0] RELOAD = TW'(TRACE_MAX);

    logic [TW-1:0] trace_q;
    logic [TW-1:0] trace_d;

    // Next trace: reload on spike, otherwise shift right by one
    always_comb begin
        trace_d = trace_q;
        if (spike_i) begin
            trace_d = RELOAD;
        end else begin
            trace_d = {1'b0, trace_q[TW-1:1]};
        end
    end

    // Trace register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_q <= '0;
        end else begin
            trace_q <= trace_d;
        end
    end

    assign trace_o = trace_q;

endmodule

// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse. Consumes pre/post spike pulses, keeps one
// halving eligibility trace per side, adjusts an on-chip weight with
// saturation and drives weight*pre_spike as current to the next neuron.
// Optional build macro STDP_TRACE_OUT_EN adds debug outputs that mirror
// the trace registers and the FSM state.
module stdp_synapse
    import stdp_pkg::*;
#(
    parameter int W_WIDTH   = 8,
    parameter int W_INIT    = 64,
    parameter int W_MAX     = 255,
    parameter int W_MIN     = 0,
    parameter int TRACE_MAX = TRACE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    output logic [W_WIDTH-1:0] syn_current,
    output logic [W_WIDTH-1:0] weight,
    output logic               w_update
`ifdef STDP_TRACE_OUT_EN
    ,
    output logic [trace_w(TRACE_MAX)-1:0] dbg_pre_trace,
    output logic [trace_w(TRACE_MAX)-1:0] dbg_post_trace,
    output logic [1:0]                    dbg_state
`endif
);

    localparam int TW = trace_w(TRACE_MAX);
    // Two guard bits: one for carry above W_MAX, one for sign below W_MIN
    localparam int EW = W_WIDTH + 2;

    localparam logic signed [EW-1:0]  MAX_S  = EW'(W_MAX);
    localparam logic signed [EW-1:0]  MIN_S  = EW'(W_MIN);
    localparam logic [W_WIDTH-1:0]    MAX_W  = W_WIDTH'(W_MAX);
    localparam logic [W_WIDTH-1:0]    MIN_W  = W_WIDTH'(W_MIN);
    localparam logic [W_WIDTH-1:0]    INIT_W = W_WIDTH'(W_INIT);

    logic [TW-1:0]      pre_trace_s;
    logic [TW-1:0]      post_trace_s;

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [TW-1:0]      delta_q;
    logic [TW-1:0]      delta_d;
    logic [W_WIDTH-1:0] weight_q;
    logic [W_WIDTH-1:0] weight_d;
    logic [W_WIDTH-1:0] syn_q;
    logic [W_WIDTH-1:0] syn_d;
    logic               w_update_q;
    logic               w_update_d;

    // Add or subtract delta from the weight in a widened signed domain
    // and clamp to [W_MIN, W_MAX] so the result never wraps.
    function automatic logic [W_WIDTH-1:0] sat_apply(
        input logic [W_WIDTH-1:0] w,
        input logic [TW-1:0]      d,
        input logic               dec
    );
        logic signed [EW-1:0] w_s;
        logic signed [EW-1:0] d_s;
        logic signed [EW-1:0] r_s;
        logic [W_WIDTH-1:0]   res;
        w_s = $signed({2'b00, w});
        d_s = $signed({{(EW-TW){1'b0}}, d});
        if (dec) begin
            r_s = w_s - d_s;
        end else begin
            r_s = w_s + d_s;
        end
        if (r_s > MAX_S) begin
            res = MAX_W;
        end else if (r_s < MIN_S) begin
            res = MIN_W;
        end else begin
            res = r_s[W_WIDTH-1:0];
        end
        return res;
    endfunction

    stdp_trace #(
        .TRACE_MAX (TRACE_MAX),
        .TW        (TW)
    ) u_pre_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (pre_spike),
        .trace_o (pre_trace_s)
    );

    stdp_trace #(
        .TRACE_MAX (TRACE_MAX),
        .TW        (TW)
    ) u_post_trace (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (post_spike),
        .trace_o (post_trace_s)
    );

    // Pair detection from any state, using trace values held before this edge;
    // coincident pre and post spikes never form a pair.
    always_comb begin
        state_d = ST_IDLE;
        delta_d = '0;
        if (post_spike && !pre_spike && (pre_trace_s != '0) && learn_en) begin
            state_d = ST_LTP;
            delta_d = pre_trace_s;
        end else if (pre_spike && !post_spike && (post_trace_s != '0) && learn_en) begin
            state_d = ST_LTD;
            delta_d = post_trace_s;
        end else begin
            state_d = ST_IDLE;
            delta_d = '0;
        end
    end

    // Weight commit one edge after a pair; learn_en no longer matters here
    always_comb begin
        weight_d   = weight_q;
        w_update_d = 1'b0;
        case (state_q)
            ST_LTP: begin
                weight_d   = sat_apply(weight_q, delta_q, 1'b0);
                w_update_d = 1'b1;
            end
            ST_LTD: begin
                weight_d   = sat_apply(weight_q, delta_q, 1'b1);
                w_update_d = 1'b1;
            end
            default: begin
                weight_d   = weight_q;
                w_update_d = 1'b0;
            end
        endcase
    end

    // Synaptic current carries the pre-update weight for one cycle per pre spike
    always_comb begin
        syn_d = '0;
        if (pre_spike) begin
            syn_d = weight_q;
        end else begin
            syn_d = '0;
        end
    end

    // State, delta, weight and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            delta_q    <= '0;
            weight_q   <= INIT_W;
            syn_q      <= '0;
            w_update_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            delta_q    <= delta_d;
            weight_q   <= weight_d;
            syn_q      <= syn_d;
            w_update_q <= w_update_d;
        end
    end

    assign syn_current = syn_q;
    assign weight      = weight_q;
    assign w_update    = w_update_q;

`ifdef STDP_TRACE_OUT_EN
    assign dbg_pre_trace  = pre_trace_s;
    assign dbg_post_trace = post_trace_s;
    assign dbg_state      = state_q;
`endif

endmodule

// File: tb/tb_stdp_synapse.sv
// Self-checking bench for stdp_synapse: a table of per-edge vectors with
// hand-computed expectations, plus hand-written saturation and
// reset-during-update sequences.
module tb_stdp_synapse;

    logic       clk;
    logic       rst_n;
    logic       pre_spike;
    logic       post_spike;
    logic       learn_en;
    logic [7:0] syn_current;
    logic [7:0] weight;
    logic       w_update;
`ifdef STDP_TRACE_OUT_EN
    logic [4:0] dbg_pre_trace;
    logic [4:0] dbg_post_trace;
    logic [1:0] dbg_state;
`endif

    int n_vec;
    int n_err;

    stdp_synapse dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pre_spike   (pre_spike),
        .post_spike  (post_spike),
        .learn_en    (learn_en),
        .syn_current (syn_current),
        .weight      (weight),
        .w_update    (w_update)
`ifdef STDP_TRACE_OUT_EN
        ,
        .dbg_pre_trace  (dbg_pre_trace),
        .dbg_post_trace (dbg_post_trace),
        .dbg_state      (dbg_state)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_v;
        logic       pre;
        logic       post;
        logic       learn;
        logic [7:0] syn;
        logic [7:0] w;
        logic       upd;
    } vec_t;

    vec_t vecs[$];

    function automatic void push(input logic r, input logic p, input logic q, input logic l,
                                 input logic [7:0] s, input logic [7:0] w, input logic u);
        vec_t v;
        v.rst_v = r; v.pre = p; v.post = q; v.learn = l;
        v.syn = s; v.w = w; v.upd = u;
        vecs.push_back(v);
    endfunction

    function automatic void idles(input int n, input logic l, input logic [7:0] w);
        for (int k = 0; k < n; k++) push(1'b1, 1'b0, 1'b0, l, 8'd0, w, 1'b0);
    endfunction

    // First spike, dt-1 quiet edges, second spike, commit edge, 6 quiet edges
    function automatic void pair(input logic pre_first, input int dt, input logic l,
                                 input logic [7:0] wb, input logic [7:0] wa, input logic u);
        push(1'b1, pre_first, ~pre_first, l, pre_first ? wb : 8'd0, wb, 1'b0);
        idles(dt - 1, l, wb);
        push(1'b1, ~pre_first, pre_first, l, pre_first ? 8'd0 : wb, wb, 1'b0);
        push(1'b1, 1'b0, 1'b0, l, 8'd0, wa, u);
        idles(6, l, wa);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic p, input logic q);
        pre_spike  = p;
        post_spike = q;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        rst_n = 1'b1;
        chk("reset_weight", {24'd0, weight}, 32'd64);
    endtask

    task automatic ltp(input int dt, input logic [7:0] exp_w);
        step(1'b1, 1'b0);
        repeat (dt - 1) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk($sformatf("ltp_dt%0d_weight", dt), {24'd0, weight}, {24'd0, exp_w});
        chk($sformatf("ltp_dt%0d_upd", dt), {31'd0, w_update}, 32'd1);
        repeat (6) step(1'b0, 1'b0);
    endtask

    task automatic ltd(input int dt, input logic [7:0] exp_w);
        step(1'b0, 1'b1);
        repeat (dt - 1) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk($sformatf("ltd_dt%0d_weight", dt), {24'd0, weight}, {24'd0, exp_w});
        chk($sformatf("ltd_dt%0d_upd", dt), {31'd0, w_update}, 32'd1);
        repeat (6) step(1'b0, 1'b0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        pre_spike  = 1'b0;
        post_spike = 1'b0;
        learn_en   = 1'b1;

        // Reset state, then quiet release
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd64, 1'b0);
        idles(2, 1'b1, 8'd64);
        // LTP at several spike spacings
        pair(1'b1, 2, 1'b1, 8'd64, 8'd72, 1'b1);
        pair(1'b1, 1, 1'b1, 8'd72, 8'd88, 1'b1);
        pair(1'b1, 5, 1'b1, 8'd88, 8'd89, 1'b1);
        pair(1'b1, 6, 1'b1, 8'd89, 8'd89, 1'b0);
        // LTD from a fresh reset: post then pre three edges later
        push(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd64, 1'b0);
        pair(1'b0, 3, 1'b1, 8'd64, 8'd60, 1'b1);
        // Coincident spikes: no pairing, but pre trace reloaded (next post pairs with 16)
        push(1'b1, 1'b1, 1'b1, 1'b1, 8'd60, 8'd60, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd60, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd76, 1'b1);
        idles(6, 1'b1, 8'd76);
        // Plasticity off: weight frozen
        pair(1'b1, 1, 1'b0, 8'd76, 8'd76, 1'b0);
        // learn_en drops while the update is pending: still commits
        push(1'b1, 1'b1, 1'b0, 1'b1, 8'd76, 8'd76, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd76, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd92, 1'b1);
        idles(6, 1'b1, 8'd92);
        // Back-to-back LTP then LTD with no bubble
        push(1'b1, 1'b1, 1'b0, 1'b1, 8'd92, 8'd92, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b1, 8'd0, 8'd92, 1'b0);
        push(1'b1, 1'b1, 1'b0, 1'b1, 8'd92, 8'd108, 1'b1);
        push(1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd92, 1'b1);
        idles(6, 1'b1, 8'd92);

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n      = vecs[i].rst_v;
            pre_spike  = vecs[i].pre;
            post_spike = vecs[i].post;
            learn_en   = vecs[i].learn;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d_syn", i), {24'd0, syn_current}, {24'd0, vecs[i].syn});
            chk($sformatf("row%0d_weight", i), {24'd0, weight}, {24'd0, vecs[i].w});
            chk($sformatf("row%0d_upd", i), {31'd0, w_update}, {31'd0, vecs[i].upd});
        end

        learn_en = 1'b1;

        // Upper saturation: climb to 250, then +16 clamps at 255
        do_reset();
        for (int k = 0; k < 11; k++) ltp(1, 8'(64 + 16 * (k + 1)));
        ltp(2, 8'd248);
        ltp(4, 8'd250);
        ltp(1, 8'd255);
        ltp(1, 8'd255);

        // Lower saturation: descend to 5, then -16 clamps at 0
        do_reset();
        ltd(1, 8'd48);
        ltd(1, 8'd32);
        ltd(1, 8'd16);
        ltd(2, 8'd8);
        ltd(4, 8'd6);
        ltd(5, 8'd5);
        ltd(1, 8'd0);
        ltd(1, 8'd0);

        // Reset asserted while an LTP update is pending
        do_reset();
        ltp(1, 8'd80);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_weight", {24'd0, weight}, 32'd64);
        chk("midrst_upd", {31'd0, w_update}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        chk("postrst_weight", {24'd0, weight}, 32'd64);
        chk("postrst_upd", {31'd0, w_update}, 32'd0);
        chk("postrst_syn", {24'd0, syn_current}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
